// File: rtl/inverse_butterfly_pkg.sv
// Shared definitions for the inverse butterfly: FSM state codes, counter sizing
// and a fixed-point helper.
package inverse_butterfly_pkg;

    // Handshake / datapath state codes, shared by the top FSM and the multiplier.
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Ceiling log2, usable in constant expressions; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Width of a counter that must hold 0..v-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned v);
        return (clog2(v) > 0) ? clog2(v) : 1;
    endfunction

    // Fixed-point 1.0 with the given number of fractional bits.
    function automatic logic [63:0] fx_one(input int unsigned frac);
        return 64'd1 << frac;
    endfunction

endpackage

// File: rtl/inverse_butterfly_cmult.sv
// Iterative shift-add conjugate complex multiplier: b = t * conj(w).
// One multiplier bit of w is consumed per cycle; the sign bit carries negative
// weight, so its partial product is subtracted. Each of the four real products
// is kept at full 2n-bit precision, then truncated to bits [n+d-1:d] before the
// final modulo-2^n sum/difference.
module fpcmult_conj_iter
    import inverse_butterfly_pkg::*;
#(
    parameter int unsigned n = 32,
    parameter int unsigned d = 16
) (
    input  logic         clk,
    input  logic         reset,
    // Request side: multiplicand t and twiddle w
    input  logic         req_val_i,
    output logic         req_rdy_o,
    input  logic [n-1:0] tr_i,
    input  logic [n-1:0] tc_i,
    input  logic [n-1:0] wr_i,
    input  logic [n-1:0] wc_i,
    // Response side
    output logic         resp_val_o,
    input  logic         resp_rdy_i,
    output logic [n-1:0] br_o,
    output logic [n-1:0] bc_o,
    // High during the final accumulation step; the result is valid after this edge
    output logic         last_o
);

    localparam int unsigned W2 = 2 * n;
    localparam int unsigned CW = cnt_width(n);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // Sign-extended multiplicands, shifted left by one each step
    logic [W2-1:0] mr_q, mr_d, mc_q, mc_d;
    // Multiplier words, shifted right by one each step; bit 0 is the current bit
    logic [n-1:0]  wr_q, wr_d, wc_q, wc_d;
    // Product accumulators: rr = tr*wr, cc = tc*wc, cr = tc*wr, rc = tr*wc
    logic [W2-1:0] rr_q, rr_d, cc_q, cc_d, cr_q, cr_d, rc_q, rc_d;
    logic [n-1:0]  br_q, br_d, bc_q, bc_d;
    logic          last;

    assign last       = (state_q == StMul) && (cnt_q == CW'(n - 1));
    assign req_rdy_o  = (state_q == StIdle);
    assign resp_val_o = (state_q == StDone);
    assign last_o     = last;
    assign br_o       = br_q;
    assign bc_o       = bc_q;

    // Next-state: latch operands on request, accumulate one bit per cycle, hold result
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mr_d    = mr_q;
        mc_d    = mc_q;
        wr_d    = wr_q;
        wc_d    = wc_q;
        rr_d    = rr_q;
        cc_d    = cc_q;
        cr_d    = cr_q;
        rc_d    = rc_q;
        br_d    = br_q;
        bc_d    = bc_q;
        unique case (state_q)
            StIdle: begin
                if (req_val_i) begin
                    state_d = StMul;
                    cnt_d   = '0;
                    mr_d    = {{n{tr_i[n-1]}}, tr_i};
                    mc_d    = {{n{tc_i[n-1]}}, tc_i};
                    wr_d    = wr_i;
                    wc_d    = wc_i;
                    rr_d    = '0;
                    cc_d    = '0;
                    cr_d    = '0;
                    rc_d    = '0;
                end
            end
            StMul: begin
                if (wr_q[0]) begin
                    rr_d = last ? (rr_q - mr_q) : (rr_q + mr_q);
                    cr_d = last ? (cr_q - mc_q) : (cr_q + mc_q);
                end
                if (wc_q[0]) begin
                    cc_d = last ? (cc_q - mc_q) : (cc_q + mc_q);
                    rc_d = last ? (rc_q - mr_q) : (rc_q + mr_q);
                end
                mr_d  = mr_q << 1;
                mc_d  = mc_q << 1;
                wr_d  = wr_q >> 1;
                wc_d  = wc_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = StDone;
                    // Truncate each product first, then wrap the sum/difference
                    br_d    = rr_d[n+d-1:d] + cc_d[n+d-1:d];
                    bc_d    = cr_d[n+d-1:d] - rc_d[n+d-1:d];
                end
            end
            StDone: begin
                if (resp_rdy_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mr_q    <= '0;
            mc_q    <= '0;
            wr_q    <= '0;
            wc_q    <= '0;
            rr_q    <= '0;
            cc_q    <= '0;
            cr_q    <= '0;
            rc_q    <= '0;
            br_q    <= '0;
            bc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mr_q    <= mr_d;
            mc_q    <= mc_d;
            wr_q    <= wr_d;
            wc_q    <= wc_d;
            rr_q    <= rr_d;
            cc_q    <= cc_d;
            cr_q    <= cr_d;
            rc_q    <= rc_d;
            br_q    <= br_d;
            bc_q    <= bc_d;
        end
    end

endmodule

// File: rtl/inverse_butterfly.sv
// Radix-2 inverse butterfly: a = (c + d) / 2, b = ((c - d) / 2) * conj(w).
// Sum/difference are formed in n+1 bits and floored back to n bits at
// acceptance; a is registered immediately, b comes from the iterative
// multiplier. Results are presented together while in DONE.
module inverse_butterfly
    import inverse_butterfly_pkg::*;
#(
    parameter int unsigned n = 32,
    parameter int unsigned d = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         recv_val,
    output logic         recv_rdy,
    input  logic [n-1:0] cr,
    input  logic [n-1:0] cc,
    input  logic [n-1:0] dr,
    input  logic [n-1:0] dc,
    input  logic [n-1:0] wr,
    input  logic [n-1:0] wc,
    output logic         send_val,
    input  logic         send_rdy,
    output logic [n-1:0] ar,
    output logic [n-1:0] ac,
    output logic [n-1:0] br,
    output logic [n-1:0] bc
);

    logic [1:0]   state_q, state_d;
    logic [n-1:0] ar_q, ar_d, ac_q, ac_d;
    logic [n:0]   sr_w, sc_w, tr_w, tc_w;
    logic         mul_req_val, mul_req_rdy;
    logic         mul_resp_val, mul_resp_rdy;
    logic         mul_last;

    // Handshake outputs depend on state only
    assign recv_rdy = (state_q == StIdle);
    assign send_val = (state_q == StDone);
    assign ar       = ar_q;
    assign ac       = ac_q;

    // Sum/difference in n+1 bits so the halving can never overflow
    always_comb begin
        sr_w = {cr[n-1], cr} + {dr[n-1], dr};
        sc_w = {cc[n-1], cc} + {dc[n-1], dc};
        tr_w = {cr[n-1], cr} - {dr[n-1], dr};
        tc_w = {cc[n-1], cc} - {dc[n-1], dc};
    end

    assign mul_req_val  = recv_val && recv_rdy;
    assign mul_resp_rdy = send_rdy && (state_q == StDone);

    fpcmult_conj_iter #(
        .n (n),
        .d (d)
    ) u_cmult (
        .clk        (clk),
        .reset      (reset),
        .req_val_i  (mul_req_val),
        .req_rdy_o  (mul_req_rdy),
        .tr_i       (tr_w[n:1]),
        .tc_i       (tc_w[n:1]),
        .wr_i       (wr),
        .wc_i       (wc),
        .resp_val_o (mul_resp_val),
        .resp_rdy_i (mul_resp_rdy),
        .br_o       (br),
        .bc_o       (bc),
        .last_o     (mul_last)
    );

    // FSM next-state and a-register load; floor halving is the arithmetic shift [n:1]
    always_comb begin
        state_d = state_q;
        ar_d    = ar_q;
        ac_d    = ac_q;
        unique case (state_q)
            StIdle: begin
                if (mul_req_val && mul_req_rdy) begin
                    state_d = StMul;
                    ar_d    = sr_w[n:1];
                    ac_d    = sc_w[n:1];
                end
            end
            StMul: begin
                if (mul_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (mul_resp_val && send_rdy) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state and a outputs, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ar_q    <= '0;
            ac_q    <= '0;
        end else begin
            state_q <= state_d;
            ar_q    <= ar_d;
            ac_q    <= ac_d;
        end
    end

endmodule

// File: tb/tb_inverse_butterfly.sv
// Scoreboard bench for inverse_butterfly: directed cases, backpressure,
// mid-operation reset and a back-to-back random burst checked against a
// forward-then-inverse golden model.
module tb_inverse_butterfly;
    import inverse_butterfly_pkg::*;

    localparam int N = 32;
    localparam logic [31:0] One = 32'(fx_one(16));

    typedef struct {
        logic [31:0] ar, ac, br, bc;
        bit          rt;
        int          b0r, b0c;
        int          acc;
    } exp_t;

    logic        clk, reset, recv_val, recv_rdy, send_val, send_rdy;
    logic [31:0] cr, cc, dr, dc, wr, wc, ar, ac, br, bc;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   tp_mode  = 0;
    bit   prev_sv  = 0;
    int   last_hs  = -1;

    inverse_butterfly #(.n(32), .d(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .cr       (cr),
        .cc       (cc),
        .dr       (dr),
        .dc       (dc),
        .wr       (wr),
        .wc       (wc),
        .send_val (send_val),
        .send_rdy (send_rdy),
        .ar       (ar),
        .ac       (ac),
        .br       (br),
        .bc       (bc)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    // Bit-exact inverse: floor halving, full products, truncate each to [47:16]
    function automatic void inv_model(input logic [31:0] c_r, c_c, d_r, d_c, w_r, w_c,
                                      output logic [31:0] o_ar, o_ac, o_br, o_bc);
        longint sr, sc, tr, tc;
        sr = (longint'($signed(c_r)) + longint'($signed(d_r))) >>> 1;
        sc = (longint'($signed(c_c)) + longint'($signed(d_c))) >>> 1;
        tr = (longint'($signed(c_r)) - longint'($signed(d_r))) >>> 1;
        tc = (longint'($signed(c_c)) - longint'($signed(d_c))) >>> 1;
        o_ar = 32'(sr);
        o_ac = 32'(sc);
        o_br = 32'((tr * longint'($signed(w_r))) >>> 16) + 32'((tc * longint'($signed(w_c))) >>> 16);
        o_bc = 32'((tc * longint'($signed(w_r))) >>> 16) - 32'((tr * longint'($signed(w_c))) >>> 16);
    endfunction

    task automatic scramble();
        cr = $urandom; cc = $urandom; dr = $urandom;
        dc = $urandom; wr = $urandom; wc = $urandom;
    endtask

    // Present one operand set, wait (bounded) for acceptance, push expectation
    task automatic drive(input logic [31:0] c_r, c_c, d_r, d_c, w_r, w_c, input exp_t e);
        bit ok;
        ok = 0;
        @(negedge clk);
        cr = c_r; cc = c_c; dr = d_r; dc = d_c; wr = w_r; wc = w_c;
        recv_val = 1;
        for (int i = 0; i < 200; i++) begin
            if (recv_rdy) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check_eq("accept_timeout", {31'b0, recv_rdy}, 32'd1);
            recv_val = 0;
            return;
        end
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        recv_val = 0;
        scramble();
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check_eq("drain", 32'(sb.size()), 32'd0);
    endtask

    function automatic exp_t mk(input logic [31:0] a_r, a_c, b_r, b_c);
        exp_t e;
        e.ar = a_r; e.ac = a_c; e.br = b_r; e.bc = b_c;
        e.rt = 0; e.b0r = 0; e.b0c = 0; e.acc = 0;
        return e;
    endfunction

    // Output monitor: latency on send_val rise, data compare on handshake
    always @(negedge clk) begin
        exp_t e;
        int   dif;
        if (reset) begin
            prev_sv = 0;
            last_hs = -1;
        end else begin
            if (send_val && !prev_sv) begin
                if (sb.size() > 0) check_eq("latency", 32'(cyc - sb[0].acc), 32'(N));
                else check_eq("stray_send_val", {31'b0, send_val}, 32'd0);
            end
            if (send_val && send_rdy && sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("ar", ar, e.ar);
                check_eq("ac", ac, e.ac);
                check_eq("br", br, e.br);
                check_eq("bc", bc, e.bc);
                if (e.rt) begin
                    dif = $signed(br) - e.b0r;
                    check_eq("roundtrip_br_2lsb", {31'b0, (dif >= -2 && dif <= 2)}, 32'd1);
                    dif = $signed(bc) - e.b0c;
                    check_eq("roundtrip_bc_2lsb", {31'b0, (dif >= -2 && dif <= 2)}, 32'd1);
                end
                if (tp_mode) begin
                    if (last_hs >= 0) check_eq("interval", 32'(cyc - last_hs), 32'(N + 2));
                    last_hs = cyc;
                end
            end
            if (!tp_mode) last_hs = -1;
            prev_sv = send_val;
        end
    end

    initial begin
        int wr_t[6] = '{65536, 0, -65536, 0, 46341, 46341};
        int wc_t[6] = '{0, 65536, 0, -65536, 46341, -46341};
        exp_t e;
        int   cnt;

        reset = 0; recv_val = 0; send_rdy = 1;
        cr = 0; cc = 0; dr = 0; dc = 0; wr = 0; wc = 0;
        #1 reset = 1;
        #2;
        check_eq("rst_ar", ar, 32'd0);
        check_eq("rst_ac", ac, 32'd0);
        check_eq("rst_br", br, 32'd0);
        check_eq("rst_bc", bc, 32'd0);
        check_eq("rst_send_val", {31'b0, send_val}, 32'd0);
        check_eq("rst_recv_rdy", {31'b0, recv_rdy}, 32'd1);
        repeat (2) @(posedge clk);
        #2 reset = 0;

        // w = 1
        drive(32'h0003_0000, 0, One, 0, One, 0, mk(32'h0002_0000, 0, One, 0));
        drain();
        // w = j
        drive(0, 0, 32'h0002_0000, 0, 0, One, mk(One, 0, 0, One));
        drain();
        // Floor rounding
        drive(32'h0000_0001, 0, 0, 0, One, 0, mk(0, 0, 0, 0));
        drain();
        drive(32'hFFFF_FFFF, 0, 0, 0, One, 0, mk(32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0));
        drain();

        // Backpressure: hold send_rdy low for 5 cycles with a recv_val pulse in DONE
        send_rdy = 0;
        e = mk(32'h0003_0000, One, 32'h0002_0000, One);
        drive(32'h0005_0000, 32'h0002_0000, One, 0, One, 0, e);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (send_val) break;
        end
        check_eq("bp_send_val", {31'b0, send_val}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_hold_ar", ar, e.ar);
            check_eq("bp_hold_br", br, e.br);
            check_eq("bp_hold_bc", bc, e.bc);
            check_eq("bp_recv_rdy", {31'b0, recv_rdy}, 32'd0);
            recv_val = (i == 2);
        end
        @(posedge clk);
        #1 recv_val = 0;
        send_rdy = 1;
        @(negedge clk);
        @(negedge clk);
        check_eq("bp_recv_rdy_after", {31'b0, recv_rdy}, 32'd1);
        check_eq("bp_send_val_after", {31'b0, send_val}, 32'd0);
        check_eq("bp_keep_ac", ac, e.ac);
        check_eq("bp_keep_bc", bc, e.bc);
        drain();

        // Reset in the middle of a multiply
        drive(32'h0007_0000, 32'h0000_1234, 0, 0, One, 0, mk(0, 0, 0, 0));
        repeat (10) @(posedge clk);
        #2 reset = 1;
        #1;
        check_eq("mid_rst_ar", ar, 32'd0);
        check_eq("mid_rst_ac", ac, 32'd0);
        check_eq("mid_rst_br", br, 32'd0);
        check_eq("mid_rst_bc", bc, 32'd0);
        check_eq("mid_rst_send_val", {31'b0, send_val}, 32'd0);
        sb.delete();
        @(posedge clk);
        #2 reset = 0;
        cnt = 0;
        @(negedge clk);
        check_eq("post_rst_recv_rdy", {31'b0, recv_rdy}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            if (send_val) cnt++;
            @(negedge clk);
        end
        check_eq("post_rst_no_send_val", 32'(cnt), 32'd0);

        // Back-to-back random: forward butterfly in the bench, inverse in the DUT
        tp_mode = 1;
        for (int k = 0; k < 10; k++) begin
            int     idx, a0r, a0c, b0r, b0c;
            longint wbr, wbc;
            logic [31:0] c_r, c_c, d_r, d_c, o_ar, o_ac, o_br, o_bc;
            idx = (k < 6) ? k : int'($urandom_range(5, 0));
            a0r = int'($urandom_range(2097151, 0)) - 1048576;
            a0c = int'($urandom_range(2097151, 0)) - 1048576;
            b0r = int'($urandom_range(131071, 0)) - 65536;
            b0c = int'($urandom_range(131071, 0)) - 65536;
            wbr = (longint'(b0r) * wr_t[idx] - longint'(b0c) * wc_t[idx] + 32768) >>> 16;
            wbc = (longint'(b0r) * wc_t[idx] + longint'(b0c) * wr_t[idx] + 32768) >>> 16;
            c_r = 32'(longint'(a0r) + wbr);
            c_c = 32'(longint'(a0c) + wbc);
            d_r = 32'(longint'(a0r) - wbr);
            d_c = 32'(longint'(a0c) - wbc);
            inv_model(c_r, c_c, d_r, d_c, 32'(wr_t[idx]), 32'(wc_t[idx]), o_ar, o_ac, o_br, o_bc);
            e = mk(32'(a0r), 32'(a0c), o_br, o_bc);
            e.rt  = (idx < 4);
            e.b0r = b0r;
            e.b0c = b0c;
            drive(c_r, c_c, d_r, d_c, 32'(wr_t[idx]), 32'(wc_t[idx]), e);
        end
        drain();
        tp_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
